// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates writeback requesters onto the register file write port and tracks busy registers.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module regfile_wb_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           wb_req,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] wb_reg,
    input  logic [NUM_REQ*DATA_W-1:0]    wb_data,
    output logic [NUM_REQ-1:0]           wb_gnt,
    output logic                         rf_write_en,
    output logic [REG_ADDR_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]            rf_write_data,
    input  logic                         iss_valid,
    input  logic [REG_ADDR_W-1:0]        iss_reg,
    output logic                         iss_stall,
    input  logic [REG_ADDR_W-1:0]        rd_reg1,
    input  logic [REG_ADDR_W-1:0]        rd_reg2,
    output logic                         hazard1,
    output logic                         hazard2
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REGS-1:0]   busy, clr_mask, set_mask;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] gnt_reg;
    logic [DATA_W-1:0]     gnt_data;

`ifdef WB_RR_ARB_EN
    logic [IDX_W-1:0] rr_ptr, cand;
    // search begins just after the last winner so every requester gets a turn
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_gnt && wb_req[cand]) begin
                any_gnt = 1'b1;
                gnt_idx = cand;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        else if (any_gnt)
            rr_ptr <= gnt_idx;
    end
`else
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (wb_req[i]) begin
                any_gnt = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign gnt_reg   = wb_reg[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
    assign gnt_data  = wb_data[gnt_idx*DATA_W +: DATA_W];
    assign wb_gnt    = any_gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign iss_stall = iss_valid & busy[iss_reg];
    assign hazard1   = busy[rd_reg1];
    assign hazard2   = busy[rd_reg2];
    // register 0 is hardwired, so it is never reserved nor released
    assign clr_mask  = (any_gnt && gnt_reg != '0) ? (NUM_REGS'(1) << gnt_reg) : '0;
    assign set_mask  = (iss_valid && !iss_stall && iss_reg != '0) ? (NUM_REGS'(1) << iss_reg) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            busy          <= '0;
        end else begin
            busy        <= (busy & ~clr_mask) | set_mask;
            rf_write_en <= any_gnt && gnt_reg != '0;
            if (any_gnt) begin
                rf_write_reg  <= gnt_reg;
                rf_write_data <= gnt_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed bench with a commit scoreboard for regfile_wb_scheduler.
// Arbitration expectations follow WB_RR_ARB_EN when it is defined.
module tb_regfile_wb_scheduler;
    typedef struct packed {
        logic        en;
        logic [4:0]  r;
        logic [31:0] d;
    } commit_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wb_req;
    logic [9:0]  wb_reg;
    logic [63:0] wb_data;
    logic [1:0]  wb_gnt;
    logic        rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic        iss_stall;
    logic [4:0]  rd_reg1, rd_reg2;
    logic        hazard1, hazard2;

    logic [4:0]  mreg [2];
    logic [31:0] mdata [2];
    logic [4:0]  last_reg;
    logic [31:0] last_data;
    commit_t     sb [$];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    assign wb_reg  = {mreg[1], mreg[0]};
    assign wb_data = {mdata[1], mdata[0]};

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_stall(iss_stall),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // checks the grant, queues the commit it implies, then checks the commit one edge later
    task automatic step(input logic [1:0] eg);
        commit_t e;
        int i;
        #1;
        chk("wb_gnt", 32'(wb_gnt), 32'(eg));
        if (eg == 2'b00) begin
            e = '{en: 1'b0, r: last_reg, d: last_data};
        end else begin
            i = eg[1] ? 1 : 0;
            e = '{en: (mreg[i] != 5'd0), r: mreg[i], d: mdata[i]};
        end
        sb.push_back(e);
        last_reg  = e.r;
        last_data = e.d;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rf_write_en", 32'(rf_write_en), 32'(e.en));
        chk("rf_write_reg", 32'(rf_write_reg), 32'(e.r));
        chk("rf_write_data", rf_write_data, e.d);
    endtask

    initial begin
        reset = 1'b1;
        wb_req = 2'b00;
        mreg[0] = 5'd0; mreg[1] = 5'd0;
        mdata[0] = 32'd0; mdata[1] = 32'd0;
        iss_valid = 1'b0; iss_reg = 5'd0;
        rd_reg1 = 5'd0; rd_reg2 = 5'd0;
        last_reg = 5'd0; last_data = 32'd0;
        #3;
        chk("reset_en", 32'(rf_write_en), 32'd0);
        chk("reset_reg", 32'(rf_write_reg), 32'd0);
        chk("reset_data", rf_write_data, 32'd0);
        chk("reset_gnt", 32'(wb_gnt), 32'd0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;

        // register 0: granted and consumed, never written, never reserved
        wb_req = 2'b01; mreg[0] = 5'd0; mdata[0] = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_reg = 5'd0;
        #1 chk("reg0_iss_stall", 32'(iss_stall), 32'd0);
        step(2'b01);
        wb_req = 2'b00; iss_valid = 1'b0; rd_reg1 = 5'd0;
        #1 chk("reg0_hazard1", 32'(hazard1), 32'd0);

        // RAW hazard on reg 5, cleared by a commit from req1
        iss_valid = 1'b1; iss_reg = 5'd5; rd_reg1 = 5'd5; rd_reg2 = 5'd6;
        #1 chk("raw_iss_stall", 32'(iss_stall), 32'd0);
        chk("raw_hazard1_pre", 32'(hazard1), 32'd0);
        step(2'b00);
        iss_valid = 1'b0;
        #1 chk("raw_hazard1_set", 32'(hazard1), 32'd1);
        chk("raw_hazard2", 32'(hazard2), 32'd0);
        wb_req = 2'b10; mreg[1] = 5'd5; mdata[1] = 32'h12345678;
        #1 chk("raw_hazard1_commit_cycle", 32'(hazard1), 32'd1);
        step(2'b10);
        wb_req = 2'b00;
        #1 chk("raw_hazard1_after", 32'(hazard1), 32'd0);

        // WAW stall on reg 9: no reservation while stalled, reserve after commit
        iss_valid = 1'b1; iss_reg = 5'd9; rd_reg2 = 5'd9;
        #1 chk("waw_first_iss", 32'(iss_stall), 32'd0);
        step(2'b00);
        #1 chk("waw_stall", 32'(iss_stall), 32'd1);
        chk("waw_hazard2", 32'(hazard2), 32'd1);
        wb_req = 2'b01; mreg[0] = 5'd9; mdata[0] = 32'hA5A5A5A5;
        step(2'b01);
        wb_req = 2'b00;
        #1 chk("waw_stall_released", 32'(iss_stall), 32'd0);
        chk("waw_hazard2_clear", 32'(hazard2), 32'd0);
        step(2'b00);
        iss_valid = 1'b0;
        #1 chk("waw_rereserved", 32'(hazard2), 32'd1);

        // reset mid-operation with reservations and a write strobe pending
        iss_valid = 1'b1; iss_reg = 5'd3;
        step(2'b00);
        iss_reg = 5'd7; wb_req = 2'b01; mreg[0] = 5'd12; mdata[0] = 32'h0BADF00D;
        step(2'b01);
        wb_req = 2'b00; iss_valid = 1'b0; rd_reg1 = 5'd3; rd_reg2 = 5'd7;
        #1 chk("mid_hazard1", 32'(hazard1), 32'd1);
        chk("mid_hazard2", 32'(hazard2), 32'd1);
        #1 reset = 1'b1;
        #1 chk("areset_en", 32'(rf_write_en), 32'd0);
        chk("areset_reg", 32'(rf_write_reg), 32'd0);
        chk("areset_data", rf_write_data, 32'd0);
        chk("areset_hazard1", 32'(hazard1), 32'd0);
        chk("areset_hazard2", 32'(hazard2), 32'd0);
        sb.delete();
        last_reg = 5'd0; last_data = 32'd0;
        #2 reset = 1'b0;

        // both requesters held on distinct registers
        wb_req = 2'b11;
        mreg[0] = 5'd10; mdata[0] = 32'h00000111;
        mreg[1] = 5'd11; mdata[1] = 32'h00000222;
`ifdef WB_RR_ARB_EN
        step(2'b01);
        step(2'b10);
        step(2'b01);
        step(2'b10);
`else
        step(2'b01);
        step(2'b01);
        step(2'b01);
        wb_req = 2'b10;
        step(2'b10);
`endif
        wb_req = 2'b00;
        step(2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
